// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Brief    : PS/2 device-to-host receiver with clock filter, frame checker,
//            FWFT byte FIFO, level IRQ and clock-inhibit when nearly full.
// Revision : 1.0
// ============================================================================
module ps2_kbd_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_AW        = 3
) (
    input  logic       clk_chipset,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       irq,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow,
    input  logic       ovf_clr
);
    localparam int c_depth = 2 ** FIFO_AW;
    localparam int c_fw    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_tw    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_fw-1:0]  c_filt_max = c_fw'(FILTER_LEN - 1);
    localparam logic [c_tw-1:0]  c_tmo      = c_tw'(TIMEOUT_CYCLES);
    localparam logic [FIFO_AW:0] c_full     = (FIFO_AW + 1)'(c_depth);
    localparam logic [FIFO_AW:0] c_thresh   = (FIFO_AW + 1)'(c_depth - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_data   = 3'd1;
    localparam logic [2:0] c_st_parity = 3'd2;
    localparam logic [2:0] c_st_stop   = 3'd3;
    localparam logic [2:0] c_st_check  = 3'd4;

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_filt, r_fe;
    logic [c_fw-1:0] r_filt_cnt;
    logic [2:0]      r_state, w_state_next;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_sr;
    logic            r_par, r_stop;
    logic [c_tw-1:0] r_tcnt;
    logic            w_timeout, w_push, w_err_parity, w_err_frame;

    logic [7:0]         r_mem [c_depth];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0]   r_count, w_count_next;
    logic               r_ovf, r_oe;
    logic               w_full, w_do_push, w_do_pop, w_ovf_set;

    // The filtered clock only follows the synchronized pad after FILTER_LEN
    // consecutive differing samples; fe marks the 1->0 update.
    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
            r_fe       <= 1'b0;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat_i;
            r_dat_s2 <= r_dat_s1;
            r_fe     <= 1'b0;
            if (r_clk_s2 == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_filt_max) begin
                r_filt     <= r_clk_s2;
                r_filt_cnt <= '0;
                r_fe       <= ~r_clk_s2;
            end else begin
                r_filt_cnt <= r_filt_cnt + c_fw'(1);
            end
        end
    end

    assign w_timeout = (r_state != c_st_idle) && (r_tcnt >= c_tmo);

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) r_state <= c_st_idle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:   if (r_fe && !r_dat_s2) w_state_next = c_st_data;
                c_st_data:   if (r_fe && (r_bitcnt == 3'd7)) w_state_next = c_st_parity;
                c_st_parity: if (r_fe) w_state_next = c_st_stop;
                c_st_stop:   if (r_fe) w_state_next = c_st_check;
                default:     w_state_next = c_st_idle;
            endcase
        end
    end

    always_comb begin
        w_push       = 1'b0;
        w_err_parity = 1'b0;
        w_err_frame  = 1'b0;
        if (w_timeout) begin
            w_err_frame = 1'b1;
        end else if (r_state == c_st_idle) begin
            w_err_frame = r_fe && r_dat_s2;
        end else if (r_state == c_st_check) begin
            if ((^r_sr ^ r_par) != 1'b1) w_err_parity = 1'b1;
            else if (!r_stop)            w_err_frame  = 1'b1;
            else                         w_push       = 1'b1;
        end
    end

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt <= '0;
            r_sr     <= '0;
            r_par    <= 1'b0;
            r_stop   <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            if ((r_state == c_st_idle) || r_fe) r_tcnt <= '0;
            else                                r_tcnt <= r_tcnt + c_tw'(1);
            if (r_fe) begin
                case (r_state)
                    c_st_idle:   r_bitcnt <= '0;
                    c_st_data: begin
                        r_sr     <= {r_dat_s2, r_sr[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    c_st_parity: r_par  <= r_dat_s2;
                    c_st_stop:   r_stop <= r_dat_s2;
                    default:     r_bitcnt <= r_bitcnt;
                endcase
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // only overflows when no pop accompanies it.
    assign w_full    = (r_count == c_full);
    assign w_do_pop  = rd_en && (r_count != '0);
    assign w_do_push = w_push && (!w_full || w_do_pop);
    assign w_ovf_set = w_push && w_full && !w_do_pop;

    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + (FIFO_AW + 1)'(1);
            2'b01:   w_count_next = r_count - (FIFO_AW + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk_chipset) begin
        if (w_do_push) r_mem[r_wptr] <= r_sr;
    end

    always_ff @(posedge clk_chipset or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_oe    <= 1'b0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + FIFO_AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
            r_count <= w_count_next;
            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
            // Registered from next-state values so the pad never pulses mid-frame.
            r_oe <= (w_count_next >= c_thresh) && (w_state_next == c_st_idle);
        end
    end

    assign rd_valid   = (r_count != '0);
    assign irq        = rd_valid;
    assign rd_data    = rd_valid ? r_mem[r_rptr] : 8'h00;
    assign overflow   = r_ovf;
    assign ps2_clk_oe = r_oe;
    assign err_parity = w_err_parity;
    assign err_frame  = w_err_frame;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx
// Brief    : Directed self-checking bench for ps2_kbd_rx.
// Revision : 1.0
// ============================================================================
module tb_ps2_kbd_rx;
    localparam int FLEN = 8;
    localparam int TMO  = 500;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_dat_i = 1'b1;
    logic       ps2_clk_oe;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, irq, err_parity, err_frame, overflow;
    logic       ovf_clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_perr   = 0;
    int n_ferr   = 0;

    ps2_kbd_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO), .FIFO_AW(3)) dut (
        .clk_chipset(clk), .reset_n(reset_n), .ps2_clk_i(ps2_clk_i),
        .ps2_dat_i(ps2_dat_i), .ps2_clk_oe(ps2_clk_oe), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq),
        .err_parity(err_parity), .err_frame(err_frame),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_parity === 1'b1) n_perr++;
        if (err_frame === 1'b1)  n_ferr++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic pflip, input logic stp);
        return {stp, (~^d) ^ pflip, d, 1'b0};
    endfunction

    task automatic send_range(input logic [10:0] f, input int lo, input int hi, input int glitch);
        for (int i = lo; i < hi; i++) begin
            ps2_dat_i = f[i];
            if (i == glitch) begin
                cyc(5); ps2_clk_i = 1'b0; cyc(FLEN - 1); ps2_clk_i = 1'b1; cyc(HALF - 5 - (FLEN - 1));
            end else begin
                cyc(HALF);
            end
            ps2_clk_i = 1'b0; cyc(HALF); ps2_clk_i = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [10:0] f);
        send_range(f, 0, 11, -1);
        cyc(HALF);
    endtask

    task automatic pop();
        rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    endtask

    task automatic test_reset();
        cyc(3); reset_n = 1'b1; cyc(3);
        n_checks++; if ({rd_valid, irq, err_parity, err_frame, overflow, ps2_clk_oe} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {rd_valid, irq, err_parity, err_frame, overflow, ps2_clk_oe}); else n_pass++;
        n_checks++; if (rd_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rd_data); else n_pass++;
    endtask

    task automatic test_valid();
        n_perr = 0; n_ferr = 0;
        send_frame(mk(8'h1C, 1'b0, 1'b1));
        n_checks++; if (rd_valid !== 1'b1) $display("FAIL valid_rdv: got %b want 1", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== 8'h1C) $display("FAIL valid_data: got %h want 1c", rd_data); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL valid_irq: got %b want 1", irq); else n_pass++;
        n_checks++; if (n_perr + n_ferr != 0) $display("FAIL valid_noerr: got %0d want 0", n_perr + n_ferr); else n_pass++;
        pop();
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL valid_pop: got %b want 0", rd_valid); else n_pass++;
    endtask

    task automatic test_errors();
        n_perr = 0; n_ferr = 0;
        send_frame(mk(8'h1C, 1'b1, 1'b1));
        n_checks++; if (n_perr != 1) $display("FAIL parity_pulse: got %0d want 1", n_perr); else n_pass++;
        n_checks++; if (n_ferr != 0) $display("FAIL parity_noframe: got %0d want 0", n_ferr); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL parity_rdv: got %b want 0", rd_valid); else n_pass++;
        n_perr = 0; n_ferr = 0;
        send_frame(mk(8'h1C, 1'b0, 1'b0));
        n_checks++; if (n_ferr != 1) $display("FAIL stop_pulse: got %0d want 1", n_ferr); else n_pass++;
        n_checks++; if (n_perr != 0) $display("FAIL stop_noparity: got %0d want 0", n_perr); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL stop_rdv: got %b want 0", rd_valid); else n_pass++;
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 7; k++) send_frame(mk(8'(k), 1'b0, 1'b1));
        n_checks++; if (ps2_clk_oe !== 1'b1) $display("FAIL fill_oe7: got %b want 1", ps2_clk_oe); else n_pass++;
        send_range(mk(8'h08, 1'b0, 1'b1), 0, 3, -1);
        n_checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL fill_oe_midframe: got %b want 0", ps2_clk_oe); else n_pass++;
        send_range(mk(8'h08, 1'b0, 1'b1), 3, 11, -1);
        cyc(HALF);
        n_checks++; if (ps2_clk_oe !== 1'b1) $display("FAIL fill_oe8: got %b want 1", ps2_clk_oe); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fill_noovf: got %b want 0", overflow); else n_pass++;
        send_frame(mk(8'h09, 1'b0, 1'b1));
        n_checks++; if (overflow !== 1'b1) $display("FAIL fill_ovf: got %b want 1", overflow); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (rd_data !== 8'(i + 1)) $display("FAIL fill_read%0d: got %h want %h", i, rd_data, 8'(i + 1)); else n_pass++;
            pop();
            if (i == 0) begin
                n_checks++; if (ps2_clk_oe !== 1'b1) $display("FAIL fill_oe_cnt7: got %b want 1", ps2_clk_oe); else n_pass++;
            end
            if (i == 1) begin
                n_checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL fill_oe_release: got %b want 0", ps2_clk_oe); else n_pass++;
            end
        end
        pop();
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL fill_empty: got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL fill_ovf_sticky: got %b want 1", overflow); else n_pass++;
        ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fill_ovf_clr: got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_timeout();
        n_ferr = 0;
        send_range(mk(8'hF0, 1'b0, 1'b1), 0, 5, -1);
        cyc(TMO / 2);
        n_checks++; if (n_ferr != 0) $display("FAIL tmo_early: got %0d want 0", n_ferr); else n_pass++;
        cyc(TMO);
        n_checks++; if (n_ferr != 1) $display("FAIL tmo_pulse: got %0d want 1", n_ferr); else n_pass++;
        send_frame(mk(8'hAA, 1'b0, 1'b1));
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hAA) $display("FAIL tmo_next: got %b/%h want 1/aa", rd_valid, rd_data); else n_pass++;
        n_checks++; if (n_ferr != 1) $display("FAIL tmo_next_noerr: got %0d want 1", n_ferr); else n_pass++;
        pop();
    endtask

    task automatic test_glitch();
        n_perr = 0; n_ferr = 0;
        send_range(mk(8'h55, 1'b0, 1'b1), 0, 11, 4);
        cyc(HALF);
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h55) $display("FAIL glitch_data: got %b/%h want 1/55", rd_valid, rd_data); else n_pass++;
        n_checks++; if (n_perr + n_ferr != 0) $display("FAIL glitch_noerr: got %0d want 0", n_perr + n_ferr); else n_pass++;
        pop();
    endtask

    task automatic test_full_pop();
        logic [10:0] f;
        for (int k = 0; k < 8; k++) send_frame(mk(8'h10 + 8'(k), 1'b0, 1'b1));
        f = mk(8'h5A, 1'b0, 1'b1);
        send_range(f, 0, 10, -1);
        ps2_dat_i = 1'b1; cyc(HALF);
        ps2_clk_i = 1'b0; cyc(11);
        rd_en = 1'b1; cyc(1); rd_en = 1'b0;
        cyc(HALF - 12); ps2_clk_i = 1'b1; cyc(HALF);
        n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf: got %b want 0", overflow); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_data !== ((i < 7) ? 8'h11 + 8'(i) : 8'h5A))
                $display("FAIL fullpop_read%0d: got %h want %h", i, rd_data, (i < 7) ? 8'h11 + 8'(i) : 8'h5A);
            else n_pass++;
            pop();
        end
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL fullpop_empty: got %b want 0", rd_valid); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        send_frame(mk(8'h77, 1'b0, 1'b1));
        send_range(mk(8'h3C, 1'b0, 1'b1), 0, 5, -1);
        reset_n = 1'b0; #1;
        n_checks++; if ({rd_valid, irq, err_parity, err_frame, overflow, ps2_clk_oe} !== 6'b0)
            $display("FAIL rst_flags: got %b want 000000", {rd_valid, irq, err_parity, err_frame, overflow, ps2_clk_oe}); else n_pass++;
        n_checks++; if (rd_data !== 8'h00) $display("FAIL rst_data: got %h want 00", rd_data); else n_pass++;
        cyc(3); reset_n = 1'b1; cyc(3);
        send_frame(mk(8'h3C, 1'b0, 1'b1));
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) $display("FAIL rst_next: got %b/%h want 1/3c", rd_valid, rd_data); else n_pass++;
        pop();
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL rst_single: got %b want 0", rd_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_valid();
        test_errors();
        test_fill();
        test_timeout();
        test_glitch();
        test_full_pop();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
